// File: rtl/dbg_abs_cmd.sv
// -----------------------------------------------------------------------------
// dbg_abs_cmd
// Debug-module abstract-command engine for RISC-V "Access Register" commands
// (cmdtype 0) against the 32-bit GPR file. Owns data0, busy and cmderr, and
// drives one GPR read or write per accepted command while the hart is halted.
//
// Optional feature macro: DBG_AAR_POSTINC_EN
//   defined   : postincrement=1 with transfer=1 bumps the stored regno by one
//               (16-bit wrap) in DONE after an error-free command.
//   undefined : postincrement bit is ignored; stored regno never changes.
// -----------------------------------------------------------------------------
module dbg_abs_cmd (
   input  logic        clk,
   input  logic        rstn,
   input  logic        cmd_wr,
   input  logic [31:0] cmd_in,
   input  logic        cmd_rerun,
   input  logic        data0_wr,
   input  logic [31:0] data0_in,
   output logic [31:0] data0_out,
   input  logic [2:0]  cmderr_clr,
   output logic        busy,
   output logic [2:0]  cmderr,
   input  logic        halted,
   output logic [4:0]  dbg_gpr_addr,
   output logic [31:0] dbg_gpr_in,
   output logic        dbg_gpr_rd,
   output logic        dbg_gpr_wr,
   input  logic [31:0] dbg_gpr_out
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [2:0] ERR_NONE   = 3'd0;
   localparam logic [2:0] ERR_BUSY   = 3'd1;
   localparam logic [2:0] ERR_NOTSUP = 3'd2;
   localparam logic [2:0] ERR_EXCEPT = 3'd3;
   localparam logic [2:0] ERR_HALT   = 3'd4;

   // Acceptance checks in priority order; returns ERR_NONE when the command may run.
   function automatic logic [2:0] check_cmd(input logic [31:0] c, input logic hart_halted);
      logic [2:0] err;
      err = ERR_NONE;
      if (c[31:24] != 8'd0) begin
         err = ERR_NOTSUP;
      end else if (c[22:20] != 3'd2) begin
         err = ERR_NOTSUP;
      end else if (c[17] && ((c[15:0] < 16'h1000) || (c[15:0] > 16'h101F))) begin
         err = ERR_EXCEPT;
      end else if (!hart_halted) begin
         err = ERR_HALT;
      end else begin
         err = ERR_NONE;
      end
      return err;
   endfunction

   state_t      state_r, state_nxt_s;
   logic [31:0] cmd_r, cmd_nxt_s;
   logic [31:0] data0_r, data0_nxt_s;
   logic [2:0]  cmderr_r, cmderr_nxt_s;
   logic        busy_r;
   logic [4:0]  addr_r, addr_nxt_s;
   logic [31:0] gin_r, gin_nxt_s;
   logic        rd_r, rd_nxt_s;
   logic        wr_r, wr_nxt_s;

   logic        err_set_s;
   logic [2:0]  err_val_s;
   logic [2:0]  chk_s;
   logic        trig_s;
   logic        busy_ev_s;
   logic [31:0] sel_cmd_s;
   logic [31:0] data0_eff_s;

   assign trig_s      = cmd_wr | cmd_rerun;
   assign busy_ev_s   = cmd_wr | cmd_rerun | data0_wr;
   assign sel_cmd_s   = cmd_wr ? cmd_in : cmd_r;
   // data0 written in the same cycle as the command is the value the command sees
   assign data0_eff_s = data0_wr ? data0_in : data0_r;

   // Next-state, command sequencing and error detection.
   always_comb begin
      state_nxt_s = state_r;
      cmd_nxt_s   = cmd_r;
      data0_nxt_s = data0_r;
      addr_nxt_s  = addr_r;
      gin_nxt_s   = gin_r;
      rd_nxt_s    = 1'b0;
      wr_nxt_s    = 1'b0;
      err_set_s   = 1'b0;
      err_val_s   = ERR_NONE;
      chk_s       = ERR_NONE;

      case (state_r)
         ST_IDLE: begin
            data0_nxt_s = data0_eff_s;
            if (trig_s && (cmderr_r == ERR_NONE)) begin
               cmd_nxt_s = sel_cmd_s;
               chk_s     = check_cmd(sel_cmd_s, halted);
               if (chk_s != ERR_NONE) begin
                  err_set_s = 1'b1;
                  err_val_s = chk_s;
               end else begin
                  state_nxt_s = ST_EXEC;
                  if (sel_cmd_s[17]) begin
                     addr_nxt_s = sel_cmd_s[4:0];
                     if (sel_cmd_s[16]) begin
                        wr_nxt_s  = 1'b1;
                        gin_nxt_s = data0_eff_s;
                     end else begin
                        rd_nxt_s  = 1'b1;
                     end
                  end else begin
                     addr_nxt_s = addr_r;
                  end
               end
            end else begin
               cmd_nxt_s = cmd_r;
            end
         end

         ST_EXEC: begin
            state_nxt_s = ST_DONE;
            if (!halted) begin
               // hart dropped out of halt: strobes are already gated off, abandon the access
               err_set_s = 1'b1;
               err_val_s = ERR_HALT;
            end else if (busy_ev_s && (cmderr_r == ERR_NONE)) begin
               err_set_s = 1'b1;
               err_val_s = ERR_BUSY;
            end else begin
               err_set_s = 1'b0;
            end
            if (rd_r && halted) begin
               data0_nxt_s = dbg_gpr_out;
            end else begin
               data0_nxt_s = data0_r;
            end
         end

         ST_DONE: begin
            state_nxt_s = ST_IDLE;
            if (busy_ev_s && (cmderr_r == ERR_NONE)) begin
               err_set_s = 1'b1;
               err_val_s = ERR_BUSY;
            end else begin
               err_set_s = 1'b0;
            end
`ifdef DBG_AAR_POSTINC_EN
            if (cmd_r[19] && cmd_r[17] && (cmderr_r == ERR_NONE) && !err_set_s) begin
               cmd_nxt_s = {cmd_r[31:16], cmd_r[15:0] + 16'd1};
            end else begin
               cmd_nxt_s = cmd_r;
            end
`endif
         end

         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase

      // a newly raised error wins over a same-cycle clear
      if (err_set_s) begin
         cmderr_nxt_s = err_val_s;
      end else if (cmderr_clr != 3'd0) begin
         cmderr_nxt_s = cmderr_r & ~cmderr_clr;
      end else begin
         cmderr_nxt_s = cmderr_r;
      end
   end

   // State and datapath registers; reset abandons any in-flight access.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_r  <= ST_IDLE;
         cmd_r    <= 32'd0;
         data0_r  <= 32'd0;
         cmderr_r <= 3'd0;
         busy_r   <= 1'b0;
         addr_r   <= 5'd0;
         gin_r    <= 32'd0;
         rd_r     <= 1'b0;
         wr_r     <= 1'b0;
      end else begin
         state_r  <= state_nxt_s;
         cmd_r    <= cmd_nxt_s;
         data0_r  <= data0_nxt_s;
         cmderr_r <= cmderr_nxt_s;
         busy_r   <= (state_nxt_s != ST_IDLE);
         addr_r   <= addr_nxt_s;
         gin_r    <= gin_nxt_s;
         rd_r     <= rd_nxt_s;
         wr_r     <= wr_nxt_s;
      end
   end

   assign data0_out    = data0_r;
   assign busy         = busy_r;
   assign cmderr       = cmderr_r;
   assign dbg_gpr_addr = addr_r;
   assign dbg_gpr_in   = gin_r;
   // strobes drop the moment the hart leaves halt
   assign dbg_gpr_rd   = rd_r & halted;
   assign dbg_gpr_wr   = wr_r & halted;

endmodule
